pea_cmd_loader: RTL and testbench

PEA_CMD_LOADER -- requirements
Module: pea_cmd_loader

---
 rtl/pea_pkg.sv | 26 ++
 rtl/pea_cmd_decode.sv | 24 ++
 rtl/pea_cmd_loader.sv | 129 ++++++++++++
 tb/tb_pea_cmd_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the PEA command loader: opcodes, command field positions
// and the loader FSM state encoding.
package pea_pkg;

    localparam logic [2:0] OpStp = 3'b001;
    localparam logic [2:0] OpEvp = 3'b010;
    localparam logic [2:0] OpEvb = 3'b011;
    localparam logic [2:0] OpRst = 3'b101;

    localparam int unsigned OpLsb = 0;
    localparam int unsigned OpMsb = 2;
    localparam int unsigned BLsb  = 3;
    localparam int unsigned BMsb  = 7;
    localparam int unsigned NLsb  = 8;
    localparam int unsigned NMsb  = 11;

    // Payload length counter width; bounds L at 31 words.
    localparam int unsigned CntW = 5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCheck   = 2'd1,
        StPayload = 2'd2
    } state_e;

endpackage

// File: rtl/pea_cmd_decode.sv
// Combinational opcode decode: payload length L and illegal-opcode flag.
module pea_cmd_decode
    import pea_pkg::*;
(
    input  logic [2:0]      opcode_i,
    input  logic [4:0]      b_i,
    input  logic [3:0]      n_i,
    output logic [CntW-1:0] len_o,
    output logic            illegal_o
);

    always_comb begin
        len_o     = '0;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OpStp:   len_o = 5'(n_i) + 5'd1;
            OpEvp:   len_o = 5'd1;
            OpEvb:   len_o = b_i;
            OpRst:   len_o = 5'd0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pea_cmd_loader.sv
// Command/payload loader feeding separate command and data FIFOs; space for a whole
// packet is reserved before its command is written. Optional PEA_LOADER_ERRCNT_EN adds err_count.
module pea_cmd_loader
    import pea_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned BUFFER_SIZE = 1024,
    localparam int unsigned FS_W       = $clog2(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [FS_W-1:0]  free_space_command,
    input  logic [FS_W-1:0]  free_space_data,
    output logic             wr_en_command,
    output logic [WIDTH-1:0] command_out,
    output logic             wr_en_data,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
`ifdef PEA_LOADER_ERRCNT_EN
    output logic [7:0]       err_count,
`endif
    output logic             err_illegal
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cmd_q, cmd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_data_q, wr_data_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              alive_q;
    logic [CntW-1:0]   len;
    logic              illegal;
    logic              space_ok;

    pea_cmd_decode u_decode (
        .opcode_i  (cmd_q[OpMsb:OpLsb]),
        .b_i       (cmd_q[BMsb:BLsb]),
        .n_i       (cmd_q[NMsb:NLsb]),
        .len_o     (len),
        .illegal_o (illegal)
    );

    assign space_ok = (free_space_command != '0) &&
                      (32'(free_space_data) >= 32'(len));

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        wr_data_d     = 1'b0;
        data_d        = data_q;
        in_ready      = 1'b0;
        wr_en_command = 1'b0;
        err_illegal   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low until the first edge after reset release.
                in_ready = alive_q;
                if (in_valid && alive_q) begin
                    cmd_d   = in_data;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (illegal) begin
                    err_illegal = 1'b1;
                    state_d     = StIdle;
                end else if (space_ok) begin
                    wr_en_command = 1'b1;
                    cnt_d         = len;
                    state_d       = (len != '0) ? StPayload : StIdle;
                end
            end
            StPayload: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_data_d = 1'b1;
                    data_d    = in_data;
                    cnt_d     = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            cnt_q     <= '0;
            wr_data_q <= 1'b0;
            data_q    <= '0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            data_q    <= data_d;
            alive_q   <= 1'b1;
        end
    end

    assign command_out = cmd_q;
    assign wr_en_data  = wr_data_q;
    assign data_out    = data_q;
    assign busy        = (state_q != StIdle);

`ifdef PEA_LOADER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_illegal && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_pea_cmd_loader.sv
// Self-checking bench for pea_cmd_loader: packet-level scoreboard model checked every
// cycle, plus directed packet scenarios with literal expectations.
module tb_pea_cmd_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [9:0]  free_space_command;
    logic [9:0]  free_space_data;
    logic        wr_en_command;
    logic [15:0] command_out;
    logic        wr_en_data;
    logic [15:0] data_out;
    logic        busy;
    logic        err_illegal;
`ifdef PEA_LOADER_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int tests = 0;
    int fails = 0;

    pea_cmd_loader #(
        .WIDTH       (16),
        .BUFFER_SIZE (1024)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .free_space_command (free_space_command),
        .free_space_data    (free_space_data),
        .wr_en_command      (wr_en_command),
        .command_out        (command_out),
        .wr_en_data         (wr_en_data),
        .data_out           (data_out),
        .busy               (busy),
`ifdef PEA_LOADER_ERRCNT_EN
        .err_count          (err_count),
`endif
        .err_illegal        (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Payload length from the opcode rules; -1 marks an illegal opcode.
    function automatic int plen(input logic [15:0] w);
        case (w[2:0])
            3'd1:    return int'(w[11:8]) + 1;
            3'd2:    return 1;
            3'd3:    return int'(w[7:3]);
            3'd5:    return 0;
            default: return -1;
        endcase
    endfunction

    // Scoreboard state and write logs.
    logic [15:0] cmd_log[$];
    logic [15:0] data_log[$];
    logic [15:0] exp_q[$];
    int          err_seen = 0;
    int          m_rem, m_len, m_errs;
    bit          m_wait, m_ill, m_fresh, pend_v, exp_w;
    logic [15:0] m_cmd, pend_d;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_strobes", 32'({wr_en_command, wr_en_data, busy, err_illegal}), 32'd0);
            chk("rst_command_out", 32'(command_out), 32'd0);
            chk("rst_data_out", 32'(data_out), 32'd0);
            m_rem = 0; m_wait = 0; pend_v = 0; m_fresh = 1; m_errs = 0;
        end else begin
            if (wr_en_command) cmd_log.push_back(command_out);
            if (wr_en_data) data_log.push_back(data_out);
            if (err_illegal) err_seen++;
`ifdef PEA_LOADER_ERRCNT_EN
            chk("err_count", 32'(err_count), 32'((m_errs > 255) ? 255 : m_errs));
`endif
            chk("wr_en_data", 32'(wr_en_data), 32'(pend_v));
            if (pend_v) chk("data_out", 32'(data_out), 32'(pend_d));
            pend_v = 0;
            if (m_fresh) begin
                chk("ready_first_cycle", 32'(in_ready), 32'd0);
                chk("busy_first_cycle", 32'(busy), 32'd0);
                chk("cmd_first_cycle", 32'(wr_en_command), 32'd0);
                m_fresh = 0;
            end else if (m_wait) begin
                exp_w = !m_ill && (free_space_command != 0) &&
                        (int'(free_space_data) >= m_len);
                chk("check_in_ready", 32'(in_ready), 32'd0);
                chk("check_busy", 32'(busy), 32'd1);
                chk("wr_en_command", 32'(wr_en_command), 32'(exp_w));
                chk("err_illegal", 32'(err_illegal), 32'(m_ill));
                if (exp_w) chk("command_out", 32'(command_out), 32'(m_cmd));
                if (m_ill) m_errs++;
                if (exp_w || m_ill) begin
                    m_wait = 0;
                    if (exp_w) m_rem = m_len;
                end
            end else begin
                chk("in_ready", 32'(in_ready), 32'd1);
                chk("busy", 32'(busy), 32'(m_rem > 0));
                chk("no_cmd_write", 32'(wr_en_command), 32'd0);
                chk("no_err", 32'(err_illegal), 32'd0);
                if (in_valid) begin
                    if (m_rem > 0) begin
                        pend_v = 1; pend_d = in_data; m_rem--;
                    end else begin
                        m_wait = 1; m_cmd = in_data; m_len = plen(in_data);
                        m_ill = (m_len < 0);
                    end
                end
            end
        end
    end

    // Offer one word at posedge+1 and hold it until accepted (bounded).
    task automatic send(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input logic [15:0] got[$],
                           input logic [15:0] exp[$]);
        chk({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk({nm, "_word"}, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        data_log.delete();
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        free_space_command = 10'd1023;
        free_space_data = 10'd1023;

        chk("model_stp_len", 32'(plen(16'h0201)), 32'd3);
        chk("model_illegal", 32'(plen(16'h0007)), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // EVB b=3 with three payload words back to back.
        clear_logs();
        send(16'h001B); send(16'h0005); send(16'h0006); send(16'h0007);
        idle(2);
        exp_q = {16'h001B};                   chk_log("evb_cmd", cmd_log, exp_q);
        exp_q = {16'h0005, 16'h0006, 16'h0007}; chk_log("evb_data", data_log, exp_q);
        chk("evb_busy_after", 32'(busy), 32'd0);

        // STP N=2 stalls while data FIFO has room for only 2.
        clear_logs();
        free_space_data = 10'd2;
        send(16'h0201);
        idle(4);
        chk("stp_stall_writes", 32'(cmd_log.size()), 32'd0);
        chk("stp_stall_busy", 32'(busy), 32'd1);
        free_space_data = 10'd3;
        send(16'h0011); send(16'h0022); send(16'h0033);
        idle(2);
        exp_q = {16'h0201};                     chk_log("stp_cmd", cmd_log, exp_q);
        exp_q = {16'h0011, 16'h0022, 16'h0033}; chk_log("stp_data", data_log, exp_q);
        free_space_data = 10'd1023;

        // RST opcode: command only, idle two cycles after the handshake edge.
        clear_logs();
        send(16'h0005);
        idle(1);
        chk("rst_op_busy", 32'(busy), 32'd0);
        idle(1);
        exp_q = {16'h0005}; chk_log("rst_op_cmd", cmd_log, exp_q);
        exp_q = {};         chk_log("rst_op_data", data_log, exp_q);

        // Illegal opcode 111, then the next word is a command.
        clear_logs();
        send(16'h0007);
        idle(2);
        chk("illegal_pulses", 32'(err_seen), 32'd1);
        chk("illegal_writes", 32'(cmd_log.size() + data_log.size()), 32'd0);
        send(16'h0005);
        idle(2);
        exp_q = {16'h0005}; chk_log("after_illegal_cmd", cmd_log, exp_q);
`ifdef PEA_LOADER_ERRCNT_EN
        chk("err_count_one", 32'(err_count), 32'd1);
`endif

        // Command FIFO full: EVP waits, data FIFO at exactly 1 slot.
        clear_logs();
        free_space_command = 10'd0;
        free_space_data = 10'd1;
        send(16'h0002);
        idle(3);
        chk("cmd_full_writes", 32'(cmd_log.size()), 32'd0);
        free_space_command = 10'd1;
        idle(1);
        send(16'h00BB);
        idle(2);
        exp_q = {16'h0002}; chk_log("cmd_full_cmd", cmd_log, exp_q);
        exp_q = {16'h00BB}; chk_log("cmd_full_data", data_log, exp_q);
        free_space_command = 10'd1023;
        free_space_data = 10'd1023;

        // EVB with b=0: command only.
        clear_logs();
        send(16'h0003);
        idle(2);
        exp_q = {16'h0003}; chk_log("evb0_cmd", cmd_log, exp_q);
        exp_q = {};         chk_log("evb0_data", data_log, exp_q);

        // EVP with in_valid toggling 1-0-1 around the payload word.
        clear_logs();
        in_valid = 1'b1; in_data = 16'h0002;
        @(posedge clk); #1; in_data = 16'h1234;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; in_data = '0;
        idle(2);
        exp_q = {16'h0002}; chk_log("toggle_cmd", cmd_log, exp_q);
        exp_q = {16'h1234}; chk_log("toggle_data", data_log, exp_q);

        // Reset after one of three EVB payload words.
        clear_logs();
        send(16'h001B); send(16'h0005);
        rst = 1'b0;
        #1;
        chk("midrst_outputs",
            32'({in_ready, wr_en_command, wr_en_data, busy, err_illegal}), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        clear_logs();
        idle(2);
        rst = 1'b1;
        send(16'h0002); send(16'h00AA);
        idle(2);
        exp_q = {16'h0002}; chk_log("midrst_cmd", cmd_log, exp_q);
        exp_q = {16'h00AA}; chk_log("midrst_data", data_log, exp_q);

        // STP N=15: sixteen words back to back.
        clear_logs();
        send(16'h0F01);
        for (int i = 0; i < 16; i++) send(16'(16'h0100 + i));
        idle(2);
        chk("stp16_data_count", 32'(data_log.size()), 32'd16);
        if (data_log.size() == 16) chk("stp16_last", 32'(data_log[15]), 32'h010F);
        chk("stp16_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
